// File: rtl/latency_encoding_mul_arbiter.sv
// Round-robin arbiter sharing one signed x unsigned multiplier across lanes.
// `define LATENCY_ENCODING_MUL_ARB_PRIO_EN gives requester 0 fixed priority.
module latency_encoding_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 23,
    parameter int DIN1_WIDTH = 22,
    parameter int DOUT_WIDTH = 45,
    parameter int ID_WIDTH   = 2
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_WIDTH-1:0]              rsp_id,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
    output logic                             busy
);

    logic                          stall;
    logic                          accept;
    logic                          gnt_found;
    logic [ID_WIDTH-1:0]           gnt_id;
    logic [ID_WIDTH-1:0]           last;
    logic                          last_upd;

    logic                          s1_valid;
    logic [ID_WIDTH-1:0]           s1_id;
    logic signed [DIN0_WIDTH-1:0]  s1_din0;
    logic [DIN1_WIDTH-1:0]         s1_din1;

    logic signed [DOUT_WIDTH-1:0]  op0_ext;
    logic signed [DOUT_WIDTH-1:0]  op1_ext;
    logic signed [DOUT_WIDTH-1:0]  prod;

    function automatic logic [ID_WIDTH-1:0] wrap_idx(input int v);
        return ID_WIDTH'(v % NUM_REQ);
    endfunction

    assign stall = rsp_valid && !rsp_ready;

    // Cyclic search starting just after the last accepted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_found && req_valid[wrap_idx(int'(last) + k)]) begin
                gnt_found = 1'b1;
                gnt_id    = wrap_idx(int'(last) + k);
            end
        end
`ifdef LATENCY_ENCODING_MUL_ARB_PRIO_EN
        if (req_valid[0]) begin
            gnt_found = 1'b1;
            gnt_id    = '0;
        end
`endif
    end

    assign accept = ap_rst_n && gnt_found && !stall;

`ifdef LATENCY_ENCODING_MUL_ARB_PRIO_EN
    assign last_upd = accept && (gnt_id != '0);
`else
    assign last_upd = accept;
`endif

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign op0_ext = {{(DOUT_WIDTH-DIN0_WIDTH){s1_din0[DIN0_WIDTH-1]}}, s1_din0};
    assign op1_ext = {{(DOUT_WIDTH-DIN1_WIDTH){1'b0}}, s1_din1};
    assign prod    = op0_ext * op1_ext;

    assign busy = s1_valid || rsp_valid;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            last      <= ID_WIDTH'(NUM_REQ - 1);
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_din0   <= '0;
            s1_din1   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_dout  <= '0;
        end else if (!stall) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id   <= s1_id;
                rsp_dout <= prod;
            end
            s1_valid <= accept;
            if (accept) begin
                s1_id   <= gnt_id;
                s1_din0 <= req_din0[gnt_id*DIN0_WIDTH +: DIN0_WIDTH];
                s1_din1 <= req_din1[gnt_id*DIN1_WIDTH +: DIN1_WIDTH];
            end
            if (last_upd) begin
                last <= gnt_id;
            end
        end
    end

endmodule

// File: doc/latency_encoding_mul_arbiter.md
# latency_encoding_mul_arbiter

Shares one signed×unsigned multiplier (23-bit signed × 22-bit unsigned → 45-bit signed) among NUM_REQ requesters in the latency-encoding datapath. Each requester is typically a pixel-to-spike-time scaling lane. The block arbitrates round-robin, registers the winning operands, registers the product, and returns it on a shared response channel tagged with the requester index. It sits between the per-lane encoders and the single DSP multiplier the lanes share.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DIN0_WIDTH, 23, signed operand width
- DIN1_WIDTH, 22, unsigned operand width
- DOUT_WIDTH, 45, product width; must equal DIN0_WIDTH+DIN1_WIDTH
- ID_WIDTH, 2, width of rsp_id; must satisfy 2^ID_WIDTH ≥ NUM_REQ
- ap_clk  in  1  single clock, rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_din0  in  NUM_REQ*DIN0_WIDTH  signed operands, requester i at [i*DIN0_WIDTH +: DIN0_WIDTH]
- req_din1  in  NUM_REQ*DIN1_WIDTH  unsigned operands, same packing
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  ID_WIDTH  index of the requester that owns rsp_dout
- rsp_dout  out  DOUT_WIDTH  signed product
- busy  out  1  any pipeline stage holds a transaction

## Operation
- Arithmetic: product = $signed(din0) * $signed({1'b0, din1}), full DOUT_WIDTH, no truncation or rounding.
- Two-stage pipeline:
  - S1 holds the operand register, s1_id and s1_valid.
  - S2 holds the product register, which drives rsp_dout, rsp_id and rsp_valid.
- stall = rsp_valid && !rsp_ready. When stall is high, S1 and S2 hold. When stall is low, S2 loads from S1 and S1 loads from the accepted request, or clears s1_valid if nothing is accepted.
- Arbitration is round-robin with pointer last:
  - The grant is the first i with req_valid[i], searching cyclically from last+1.
  - req_ready[grant] = !stall. All other req_ready bits are 0.
  - last updates to grant only on an accepted handshake (req_valid && req_ready).
  - A requester whose valid drops before acceptance loses nothing; the pointer does not move.
- Requesters must hold req_valid and operands stable until accepted. req_ready combinationally depends on req_valid and rsp_ready; this path is permitted.
- busy = s1_valid || rsp_valid.
- Reset (ap_rst_n low, any time including mid-transaction):
  - Asynchronously clears s1_valid, rsp_valid, rsp_id, rsp_dout and the operand registers to 0.
  - Sets last = NUM_REQ-1, so requester 0 wins first.
  - Forces req_ready = 0 while ap_rst_n is low.
  - In-flight transactions are dropped and never reported.

## Timing
- Latency: a request accepted in cycle c appears with rsp_valid=1 in cycle c+2 if there is no stall.
- Throughput: one accept per cycle sustained while rsp_ready=1.
- A stall of k cycles delays all in-flight results by k cycles.
- No result is lost or duplicated under stall. rsp_dout and rsp_id are stable while rsp_valid && !rsp_ready.
- Simultaneous events: in the same cycle a request is accepted into S1, S1 advances to S2, and S2 is consumed.
- With no request pending and no stall, the pipeline drains in 2 cycles; busy falls in cycle c+3 after the last response is consumed in c+2.
- Reset outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_dout=0, busy=0.

## Configuration
- LATENCY_ENCODING_MUL_ARB_PRIO_EN
  - Defined: requester 0 has fixed priority. Whenever req_valid[0]=1 it wins regardless of pointer; last is not updated on its grants. Remaining requesters rotate round-robin among themselves.
  - Undefined: pure round-robin over all NUM_REQ requesters, as described in Operation.

## Test plan
- Single request, default parameters: req 2 with din0=-3, din1=5, rsp_ready=1 → accepted cycle c; rsp_valid cycle c+2 with rsp_id=2 and rsp_dout=-15 (45-bit sign-extended). Width extremes: din0=-2^22, din1=2^22-1 → rsp_dout=-(2^22)(2^22-1).
- Fairness: all 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1… one per cycle; each rsp_dout matches its own operands. With PRIO_EN defined, the order is 0,0,0… while req 0 stays valid.
- Backpressure: stream of 6 requests, rsp_ready=0 for 3 cycles after the first rsp_valid → rsp_dout/rsp_id held; req_ready=0 during the stall; all 6 results delivered in order, none duplicated.
- Sparse/withdrawn request: req 1 valid for one cycle while the pipeline is stalled, then dropped → no response for req 1; pointer unchanged; the next grant follows the prior order.
- Reset mid-operation: ap_rst_n low with both stages full → immediately rsp_valid=0, busy=0, req_ready=0. After release, the first grant goes to req 0 and no stale result appears.
- Random: 10k cycles of random valids, operands and rsp_ready vs a scoreboard model → exact product/id match, in-order delivery, and no requester starved for more than NUM_REQ accepts (round-robin build).
